fiber_rx: RTL and testbench
===========================

# fiber_rx

Controller-side receiver for the power-unit fiber uplink. It deserializes the fixed frame that the unit's fiber transmitter emits:
- idle-high line, one start bit (0);
- 12-bit DC-link voltage, MSB first;
- 8-bit unit status, MSB first;
- 4-bit checksum, MSB first;
- idle-high gap.

It checks the checksum and stop level and publishes validated words, error pulses and a link-alive flag to the controller logic.

## Interface
- BIT_CLKS, 10, clk cycles per bit (4 MHz line at 40 MHz clk)
- LINK_TIMEOUT, 2400, clk cycles without a good frame before link_ok drops (~4 frame periods of 570 clk)
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- comm_r  in  1  raw fiber receiver output, asynchronous to clk, idle high
- udc_volt  out  12  last validated voltage word; reset 0
- err_info  out  8  last validated status word; reset 0
- frame_vld  out  1  one-clk pulse when udc_volt/err_info update; reset 0
- chk_err  out  1  one-clk pulse on checksum mismatch; reset 0
- frm_err  out  1  one-clk pulse on stop-level low; reset 0
- link_ok  out  1  level, high while good frames arrive; reset 0

## Operation
- comm_r passes through a 2-FF synchronizer, giving `rxs`.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: on `rxs`==0, go to START and clear the phase counter.
- Phase counter: runs 0..BIT_CLKS-1 and wraps. A sample is taken when phase == BIT_CLKS/2 (integer division).
- START: sample the start bit.
  - If the sample is 1: glitch. Return to IDLE with no flags.
  - If the sample is 0: go to DATA with bit_cnt=0.
- DATA: sample and shift 24 bits MSB first, in slot order:
  - volt[11:0]
  - info[7:0]
  - chk[3:0]
- After bit_cnt reaches 23, go to STOP.
- STOP: sample one bit (slot 25, first idle slot of the frame), then always return to IDLE.
  - If the sample is 0: pulse frm_err. Outputs hold.
  - If the sample is 1 and `chk` == low 4 bits of (volt[3:0]+volt[7:4]+volt[11:8]+info[3:0]+info[7:4]): load udc_volt and err_info, pulse frame_vld.
  - If the sample is 1 and the checksum does not match: pulse chk_err. Outputs hold.
- Checksum arithmetic: 7-bit sum, compare bits [3:0] only.
- IDLE is re-entered with `rxs` high. A low line in IDLE immediately starts a new frame, so there is no gap requirement.
- Link supervision: link_cnt is 12 bits, saturating at LINK_TIMEOUT.
  - Cleared on each frame_vld; otherwise increments.
  - When link_cnt == LINK_TIMEOUT, link_ok goes 0.
  - frame_vld sets link_ok to 1.
  - If a good frame and the timeout occur in the same cycle, the good frame wins: link_ok=1 and the counter clears.
- Outputs udc_volt/err_info are never cleared by timeout; they hold the last good values.
- Reset mid-frame: all state and outputs return to reset values immediately. The partial frame is discarded; the receiver resyncs on the next falling edge.

## Timing
- Pin falling edge to IDLE detection: 2 clk (3 with filter).
- Start sample: BIT_CLKS/2 clk after detection. Data bit k (0..23) is sampled BIT_CLKS·(k+1) clk after the start sample.
- Stop sample: 25·BIT_CLKS + BIT_CLKS/2 clk after detection.
- frame_vld / chk_err / frm_err: registered, asserted the clk after the stop sample, exactly 1 cycle wide. At most one of the three pulses fires per frame.
- udc_volt/err_info change in the same cycle frame_vld is high.
- link_ok falls the clk after link_cnt reaches LINK_TIMEOUT.

## Configuration
- FIBER_RX_GLITCH_FILTER_EN defined: `rxs` is the 2-of-3 majority of the last three synchronized samples. This suppresses single-clk spikes and adds 1 clk latency everywhere.
- Undefined: `rxs` is the direct synchronizer output.

## Structure
- Package fiber_pkg holds:
  - BIT_CLKS default
  - FRAME_SLOTS=57
  - DATA_BITS=24
  - the FSM state enum
  - function fiber_chk(volt, info) returning 4 bits, shared with the transmitter
- Sub-module fiber_rx_sync: 2-FF synchronizer plus the optional majority filter under the macro.

## Test plan
- Good frame volt=0xA5C, info=0x3E, chk=0xC (sum 0x2C), at 570-clk period → frame_vld each frame, udc_volt=0xA5C, err_info=0x3E, link_ok=1 after the first frame.
- Same frame with chk=0xD → chk_err pulse, no frame_vld, outputs keep previous values.
- Good frame with line forced low at stop slot → frm_err only.
- 2-clk low spike on idle line → no flags, FSM back in IDLE. With the macro, a 1-clk spike is not even detected.
- Stop frames after a good one → link_ok drops LINK_TIMEOUT+1 clk after the last frame_vld; outputs hold. The next good frame raises link_ok.
- Assert rst_n low at data bit 10, release, then send a good frame 0x000/0x00, chk 0x0 → all outputs 0 during reset, then one clean frame_vld.

Source files
------------

// File: rtl/fiber_pkg.sv
// Shared definitions for the power-unit fiber uplink (receiver and transmitter).
package fiber_pkg;
  localparam int BIT_CLKS_DEF     = 10;
  localparam int LINK_TIMEOUT_DEF = 2400;
  localparam int FRAME_SLOTS      = 57;
  localparam int DATA_BITS        = 24;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} rx_state_e;

  // Nibble sum of the payload, low 4 bits kept; must match the transmitter.
  function automatic logic [3:0] fiber_chk(input logic [11:0] volt, input logic [7:0] info);
    logic [6:0] sum;
    sum = 7'(volt[3:0]) + 7'(volt[7:4]) + 7'(volt[11:8]) + 7'(info[3:0]) + 7'(info[7:4]);
    return sum[3:0];
  endfunction
endpackage

// File: rtl/fiber_rx_sync.sv
// 2-FF synchronizer for the fiber line; FIBER_RX_GLITCH_FILTER_EN adds a 2-of-3 majority filter.
module fiber_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rxs
);
  logic [1:0] ff;

  // Idle-high reset value so release of reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= 2'b11;
    else        ff <= {ff[0], din};

`ifdef FIBER_RX_GLITCH_FILTER_EN
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hist <= 2'b11;
    else        hist <= {hist[0], ff[1]};

  assign rxs = (ff[1] & hist[0]) | (ff[1] & hist[1]) | (hist[0] & hist[1]);
`else
  assign rxs = ff[1];
`endif
endmodule

// File: rtl/fiber_rx.sv
// Fiber uplink receiver: deserializes start/volt/info/chk/stop frames, validates, supervises link.
// Optional FIBER_RX_GLITCH_FILTER_EN enables majority filtering in fiber_rx_sync.
module fiber_rx
  import fiber_pkg::*;
#(
  parameter int BIT_CLKS     = BIT_CLKS_DEF,
  parameter int LINK_TIMEOUT = LINK_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        comm_r,
  output logic [11:0] udc_volt,
  output logic [7:0]  err_info,
  output logic        frame_vld,
  output logic        chk_err,
  output logic        frm_err,
  output logic        link_ok
);
  localparam int             PW        = $clog2(BIT_CLKS);
  localparam logic [PW-1:0]  SAMPLE_PH = PW'(BIT_CLKS / 2);
  localparam logic [PW-1:0]  LAST_PH   = PW'(BIT_CLKS - 1);
  localparam logic [4:0]     LAST_BIT  = 5'(DATA_BITS - 1);
  localparam logic [11:0]    LINK_MAX  = 12'(LINK_TIMEOUT);

  logic            rxs;
  rx_state_e       state, state_nxt;
  logic [PW-1:0]   phase;
  logic [4:0]      bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [11:0]     link_cnt;
  logic            sample, good, bad_chk, bad_stop;

  fiber_rx_sync u_sync (.clk(clk), .rst_n(rst_n), .din(comm_r), .rxs(rxs));

  assign sample = (phase == SAMPLE_PH);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!rxs) state_nxt = ST_START;
      ST_START: if (sample) state_nxt = rxs ? ST_IDLE : ST_DATA;
      ST_DATA:  if (sample && bit_cnt == LAST_BIT) state_nxt = ST_STOP;
      ST_STOP:  if (sample) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Stop-slot verdict; at most one of the three can be set.
  always_comb begin
    good     = 1'b0;
    bad_chk  = 1'b0;
    bad_stop = 1'b0;
    if (state == ST_STOP && sample) begin
      if (!rxs)
        bad_stop = 1'b1;
      else if (shreg[3:0] == fiber_chk(shreg[23:12], shreg[11:4]))
        good = 1'b1;
      else
        bad_chk = 1'b1;
    end
  end

  // Phase is held at 0 in IDLE so the first START cycle begins a fresh bit.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (state == ST_IDLE)    phase <= '0;
      else if (phase == LAST_PH) phase <= '0;
      else                     phase <= phase + 1'b1;
      if (state == ST_START)   bit_cnt <= '0;
      else if (state == ST_DATA && sample) bit_cnt <= bit_cnt + 1'b1;
      if (state == ST_DATA && sample) shreg <= {shreg[DATA_BITS-2:0], rxs};
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      udc_volt  <= '0;
      err_info  <= '0;
      frame_vld <= 1'b0;
      chk_err   <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      frame_vld <= good;
      chk_err   <= bad_chk;
      frm_err   <= bad_stop;
      if (good) begin
        udc_volt <= shreg[23:12];
        err_info <= shreg[11:4];
      end
    end

  // A good frame takes priority over the timeout in the same cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      link_cnt <= '0;
      link_ok  <= 1'b0;
    end else if (good) begin
      link_cnt <= '0;
      link_ok  <= 1'b1;
    end else begin
      if (link_cnt != LINK_MAX) link_cnt <= link_cnt + 1'b1;
      else                      link_ok  <= 1'b0;
    end
endmodule

// File: tb/tb_fiber_rx.sv
// Scoreboard bench for fiber_rx: frames driven on comm_r, verdict events compared against a model.
module tb_fiber_rx;
  localparam int BIT   = 10;
  localparam int LTO   = 2400;
  localparam int SLOTS = 57;
`ifdef FIBER_RX_GLITCH_FILTER_EN
  localparam int FLT = 1;
`else
  localparam int FLT = 0;
`endif

  typedef struct {
    int          kind;   // 0 good, 1 chk_err, 2 frm_err, 3 several at once
    logic [11:0] volt;
    logic [7:0]  info;
    int          cyc;
  } ev_t;

  logic        clk = 1'b0, rst_n = 1'b0, comm_r = 1'b1;
  logic [11:0] udc_volt;
  logic [7:0]  err_info;
  logic        frame_vld, chk_err, frm_err, link_ok;

  ev_t obs[$], exq[$];
  int  cyc = 0, nvec = 0, nerr = 0;
  logic [11:0] hold_v = '0;
  logic [7:0]  hold_i = '0;

  fiber_rx dut (.clk(clk), .rst_n(rst_n), .comm_r(comm_r), .udc_volt(udc_volt),
                .err_info(err_info), .frame_vld(frame_vld), .chk_err(chk_err),
                .frm_err(frm_err), .link_ok(link_ok));

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (frame_vld || chk_err || frm_err)) begin
      e.kind = (int'(frame_vld) + int'(chk_err) + int'(frm_err) > 1) ? 3 :
               frame_vld ? 0 : chk_err ? 1 : 2;
      e.volt = udc_volt;
      e.info = err_info;
      e.cyc  = cyc;
      obs.push_back(e);
    end
  end

  function automatic logic [3:0] ref_chk(input logic [11:0] v, input logic [7:0] i);
    logic [6:0] s;
    s = 7'(v[3:0]) + 7'(v[7:4]) + 7'(v[11:8]) + 7'(i[3:0]) + 7'(i[7:4]);
    return s[3:0];
  endfunction

  // Pushes the expected verdict, then drives one full 57-slot frame (or stops at abort_slot).
  task automatic send_frame(input logic [11:0] v, input logic [7:0] i, input logic [3:0] c,
                            input bit stop_low, input int abort_slot, output int t0);
    logic [23:0] d;
    ev_t x;
    d = {v, i, c};
    t0 = cyc;
    if (abort_slot < 0) begin
      if (stop_low)              x.kind = 2;
      else if (c == ref_chk(v, i)) x.kind = 0;
      else                       x.kind = 1;
      if (x.kind == 0) begin hold_v = v; hold_i = i; end
      x.volt = hold_v; x.info = hold_i; x.cyc = 0;
      exq.push_back(x);
    end
    for (int s = 0; s < SLOTS; s++) begin
      if (s == abort_slot) return;
      if (s == 0)       comm_r = 1'b0;
      else if (s <= 24) comm_r = d[24-s];
      else if (s == 25) comm_r = ~stop_low;
      else              comm_r = 1'b1;
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic wait_event(output ev_t e, output bit got);
    got = 1'b0;
    e = '{default: 0};
    for (int k = 0; k < 600; k++) begin
      if (obs.size() > 0) begin e = obs.pop_front(); got = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; comm_r = 1'b1;
    repeat (3) @(negedge clk);
    nvec++;
    if ({udc_volt, err_info, frame_vld, chk_err, frm_err, link_ok} !== 26'd0) begin
      nerr++; $display("FAIL reset_state: got %h required 0",
                       {udc_volt, err_info, frame_vld, chk_err, frm_err, link_ok});
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_good_frames();
    logic [11:0] vt [4] = '{12'hA5C, 12'hFFF, 12'h000, 12'h123};
    logic [7:0]  it [4] = '{8'h3E, 8'h00, 8'hFF, 8'hFF};
    int t0, prev;
    ev_t e, x;
    bit got;
    prev = 0;
    for (int n = 0; n < 4; n++) begin
      send_frame(vt[n], it[n], ref_chk(vt[n], it[n]), 1'b0, -1, t0);
      wait_event(e, got);
      x = exq.pop_front();
      nvec++;
      if (!got) begin nerr++; $display("FAIL good_%0d: no event, required frame_vld", n); continue; end
      if (e.kind !== x.kind || e.volt !== x.volt || e.info !== x.info) begin
        nerr++; $display("FAIL good_%0d: got kind %0d %h/%h required kind %0d %h/%h",
                         n, e.kind, e.volt, e.info, x.kind, x.volt, x.info);
      end
      nvec++;
      if (e.cyc - t0 < 256 + FLT || e.cyc - t0 > 261 + FLT) begin
        nerr++; $display("FAIL latency_%0d: got %0d required %0d..%0d", n, e.cyc - t0, 256 + FLT, 261 + FLT);
      end
      if (n > 0) begin
        nvec++;
        if (e.cyc - prev !== BIT * SLOTS) begin
          nerr++; $display("FAIL period_%0d: got %0d required %0d", n, e.cyc - prev, BIT * SLOTS);
        end
      end
      prev = e.cyc;
      nvec++;
      if (link_ok !== 1'b1) begin nerr++; $display("FAIL link_up_%0d: got %b required 1", n, link_ok); end
    end
  endtask

  task automatic test_bad_frame(input bit stop_low, input logic [3:0] c);
    int t0;
    ev_t e, x;
    bit got;
    send_frame(12'hA5C, 8'h3E, c, stop_low, -1, t0);
    wait_event(e, got);
    x = exq.pop_front();
    nvec++;
    if (!got) begin nerr++; $display("FAIL bad_frame_%0d: no event, required kind %0d", stop_low, x.kind); end
    else if (e.kind !== x.kind || e.volt !== x.volt || e.info !== x.info) begin
      nerr++; $display("FAIL bad_frame_%0d: got kind %0d %h/%h required kind %0d %h/%h",
                       stop_low, e.kind, e.volt, e.info, x.kind, x.volt, x.info);
    end
    repeat (20) @(negedge clk);
    nvec++;
    if (obs.size() !== 0) begin nerr++; $display("FAIL bad_frame_extra: got %0d events required 0", obs.size()); end
  endtask

  task automatic test_spike();
    int t0;
    ev_t e, x;
    bit got;
    for (int w = 1; w <= 2; w++) begin
      comm_r = 1'b0;
      repeat (w) @(negedge clk);
      comm_r = 1'b1;
      repeat (60) @(negedge clk);
      nvec++;
      if (obs.size() !== 0) begin nerr++; $display("FAIL spike_%0d: got %0d events required 0", w, obs.size()); end
    end
    send_frame(12'h5A3, 8'hC1, ref_chk(12'h5A3, 8'hC1), 1'b0, -1, t0);
    wait_event(e, got);
    x = exq.pop_front();
    nvec++;
    if (!got || e.kind !== x.kind || e.volt !== x.volt || e.info !== x.info) begin
      nerr++; $display("FAIL after_spike: got kind %0d %h/%h required kind %0d %h/%h",
                       e.kind, e.volt, e.info, x.kind, x.volt, x.info);
    end
  endtask

  task automatic test_timeout();
    int t0, vcyc, fall;
    ev_t e, x;
    bit got;
    send_frame(12'h7E1, 8'h42, ref_chk(12'h7E1, 8'h42), 1'b0, -1, t0);
    wait_event(e, got);
    x = exq.pop_front();
    vcyc = e.cyc;
    nvec++;
    if (!got || e.kind !== 0) begin nerr++; $display("FAIL timeout_setup: got kind %0d required 0", e.kind); end
    fall = -1;
    for (int k = 0; k < LTO + 200; k++) begin
      @(negedge clk);
      if (!link_ok) begin fall = cyc; break; end
    end
    nvec++;
    if (fall - vcyc !== LTO + 1) begin
      nerr++; $display("FAIL link_drop: got %0d clk required %0d", fall - vcyc, LTO + 1);
    end
    nvec++;
    if (udc_volt !== x.volt || err_info !== x.info) begin
      nerr++; $display("FAIL hold_after_timeout: got %h/%h required %h/%h", udc_volt, err_info, x.volt, x.info);
    end
    send_frame(12'h0F0, 8'h0F, ref_chk(12'h0F0, 8'h0F), 1'b0, -1, t0);
    wait_event(e, got);
    x = exq.pop_front();
    nvec++;
    if (!got || e.kind !== 0 || link_ok !== 1'b1) begin
      nerr++; $display("FAIL link_recover: got kind %0d link %b required kind 0 link 1", e.kind, link_ok);
    end
  endtask

  task automatic test_reset_midframe();
    int t0;
    ev_t e, x;
    bit got;
    send_frame(12'hA5C, 8'h3E, 4'hC, 1'b0, 11, t0);
    rst_n = 1'b0; comm_r = 1'b1;
    repeat (5) @(negedge clk);
    nvec++;
    if ({udc_volt, err_info, frame_vld, chk_err, frm_err, link_ok} !== 26'd0) begin
      nerr++; $display("FAIL midframe_reset: got %h required 0",
                       {udc_volt, err_info, frame_vld, chk_err, frm_err, link_ok});
    end
    rst_n = 1'b1;
    hold_v = '0; hold_i = '0;
    repeat (30) @(negedge clk);
    nvec++;
    if (obs.size() !== 0) begin nerr++; $display("FAIL post_reset_quiet: got %0d events required 0", obs.size()); end
    send_frame(12'h000, 8'h00, 4'h0, 1'b0, -1, t0);
    wait_event(e, got);
    x = exq.pop_front();
    nvec++;
    if (!got || e.kind !== x.kind || e.volt !== x.volt || e.info !== x.info || link_ok !== 1'b1) begin
      nerr++; $display("FAIL post_reset_frame: got kind %0d %h/%h link %b required kind 0 000/00 link 1",
                       e.kind, e.volt, e.info, link_ok);
    end
    repeat (20) @(negedge clk);
    nvec++;
    if (obs.size() !== 0) begin nerr++; $display("FAIL post_reset_extra: got %0d events required 0", obs.size()); end
  endtask

  initial begin
    test_reset();
    test_good_frames();
    test_bad_frame(1'b0, 4'hD);
    test_bad_frame(1'b1, 4'hC);
    test_spike();
    test_timeout();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
